// File: rtl/pfeed_pkg.sv
// Shared types and constants for the perceptron feeder.
// Build option: PFEED_STATS_EN adds the vector/zero-result counters.
package pfeed_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    HOLD
  } state_t;

  localparam int CFG_W0      = 0;
  localparam int CFG_W1      = 1;
  localparam int CFG_W2      = 2;
  localparam int CFG_W3      = 3;
  localparam int CFG_BIAS    = 4;
  localparam int CFG_THRESH  = 5;
  localparam int CFG_STATCLR = 7;

endpackage

// File: rtl/perceptron_feeder_if.sv
// Sample stream in and result stream out of the perceptron feeder.
// The slave modport is the feeder side; master is the environment side.
interface perceptron_feeder_if #(
  parameter int DW = 8
);

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/pfeed_cfg_regs.sv
// Weight, bias and threshold register file for the perceptron feeder.
// Writes to reserved addresses are accepted upstream and dropped here.
module pfeed_cfg_regs
  import pfeed_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CFG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [CFG_AW-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     w0,
  output logic [DW-1:0]     w1,
  output logic [DW-1:0]     w2,
  output logic [DW-1:0]     w3,
  output logic [DW-1:0]     bias,
  output logic [DW-1:0]     thresh
);

  logic [DW-1:0] w_q [4];
  logic [DW-1:0] bias_q;
  logic [DW-1:0] thresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      bias_q   <= '0;
      thresh_q <= '0;
    end else if (we) begin
      unique case (1'b1)
        addr == CFG_AW'(CFG_W0):     w_q[0]   <= wdata;
        addr == CFG_AW'(CFG_W1):     w_q[1]   <= wdata;
        addr == CFG_AW'(CFG_W2):     w_q[2]   <= wdata;
        addr == CFG_AW'(CFG_W3):     w_q[3]   <= wdata;
        addr == CFG_AW'(CFG_BIAS):   bias_q   <= wdata;
        addr == CFG_AW'(CFG_THRESH): thresh_q <= wdata;
        default: ;
      endcase
    end
  end

  assign w0     = w_q[0];
  assign w1     = w_q[1];
  assign w2     = w_q[2];
  assign w3     = w_q[3];
  assign bias   = bias_q;
  assign thresh = thresh_q;

endmodule

// File: rtl/perceptron_feeder.sv
// Sequential front-end for the 4-input perceptron stage.
// Build option: PFEED_STATS_EN adds stat_vec_cnt / stat_zero_cnt.
module perceptron_feeder
  import pfeed_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CFG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  perceptron_feeder_if.slave sif,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [DW-1:0]     cfg_wdata,
  output logic              cfg_ready,
  output logic [DW-1:0]     p_in0,
  output logic [DW-1:0]     p_in1,
  output logic [DW-1:0]     p_in2,
  output logic [DW-1:0]     p_in3,
  output logic [DW-1:0]     p_w0,
  output logic [DW-1:0]     p_w1,
  output logic [DW-1:0]     p_w2,
  output logic [DW-1:0]     p_w3,
  output logic [DW-1:0]     p_bias,
  output logic [DW-1:0]     p_thresh,
  input  logic [DW-1:0]     p_out,
`ifdef PFEED_STATS_EN
  output logic [15:0]       stat_vec_cnt,
  output logic [15:0]       stat_zero_cnt,
`endif
  output logic              frame_err
);

  state_t        state;
  logic [1:0]    idx;
  logic [DW-1:0] p_in_q [4];
  logic          s_ready_q;
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          cfg_wr;
  logic          beat;

  assign cfg_wr = cfg_we & cfg_ready;
  assign beat   = sif.s_valid & s_ready_q;

  pfeed_cfg_regs #(
    .DW     (DW),
    .CFG_AW (CFG_AW)
  ) u_cfg (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_wr),
    .addr   (cfg_addr),
    .wdata  (cfg_wdata),
    .w0     (p_w0),
    .w1     (p_w1),
    .w2     (p_w2),
    .w3     (p_w3),
    .bias   (p_bias),
    .thresh (p_thresh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      for (int i = 0; i < 4; i++) p_in_q[i] <= '0;
      s_ready_q <= 1'b1;
      cfg_ready <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (beat) begin
            p_in_q[idx] <= sif.s_data;
            if (idx == 2'd3) begin
              idx <= '0;
              if (sif.s_last) begin
                state     <= EVAL;
                s_ready_q <= 1'b0;
                cfg_ready <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (sif.s_last) begin
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        EVAL: begin
          m_data_q  <= p_out;
          m_valid_q <= 1'b1;
          cfg_ready <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (sif.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign sif.s_ready = s_ready_q;
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;
  assign p_in0       = p_in_q[0];
  assign p_in1       = p_in_q[1];
  assign p_in2       = p_in_q[2];
  assign p_in3       = p_in_q[3];

`ifdef PFEED_STATS_EN
  logic stat_clr;

  assign stat_clr = cfg_wr & (cfg_addr == CFG_AW'(CFG_STATCLR));

  // EVAL blocks config writes, so a clear never collides with a count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_vec_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (stat_clr) begin
      stat_vec_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (state == EVAL) begin
      if (stat_vec_cnt != 16'hFFFF)
        stat_vec_cnt <= stat_vec_cnt + 16'd1;
      if (p_out == '0 && stat_zero_cnt != 16'hFFFF)
        stat_zero_cnt <= stat_zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_feeder.sv
// Scoreboard bench for perceptron_feeder with a behavioural perceptron.
// Define PFEED_STATS_EN to also check the statistics counters.
module tb_perceptron_feeder;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_ready;
  logic [7:0] p_in0, p_in1, p_in2, p_in3;
  logic [7:0] p_w0, p_w1, p_w2, p_w3;
  logic [7:0] p_bias, p_thresh, p_out;
  logic       frame_err;
`ifdef PFEED_STATS_EN
  logic [15:0] stat_vec_cnt, stat_zero_cnt;
  int          m_vec, m_zero;
`endif

  perceptron_feeder_if #(.DW(8)) bus ();

  perceptron_feeder #(.DW(8), .CFG_AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sif       (bus),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .p_in0     (p_in0),
    .p_in1     (p_in1),
    .p_in2     (p_in2),
    .p_in3     (p_in3),
    .p_w0      (p_w0),
    .p_w1      (p_w1),
    .p_w2      (p_w2),
    .p_w3      (p_w3),
    .p_bias    (p_bias),
    .p_thresh  (p_thresh),
    .p_out     (p_out),
`ifdef PFEED_STATS_EN
    .stat_vec_cnt  (stat_vec_cnt),
    .stat_zero_cnt (stat_zero_cnt),
`endif
    .frame_err (frame_err)
  );

  // Behavioural perceptron stage: 8-bit wrap sum, zero when below threshold
  always_comb begin
    logic [7:0] acc;
    logic [7:0] diff;
    acc   = p_in0 * p_w0 + p_in1 * p_w1 + p_in2 * p_w2 + p_in3 * p_w3 + p_bias;
    diff  = acc - p_thresh;
    p_out = diff[7] ? 8'd0 : acc;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcfg[6];
  int smp_q[$];
  int exp_q[$];
  int err_exp = 0;
  int err_seen = 0;
  bit rnd_en = 0;
  bit ready_force = 1;
  bit stalled = 0;
  int held = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int ref_out(input int x[$]);
    int s;
    int d;
    s = mcfg[4];
    for (int i = 0; i < 4; i++) s += x[i] * mcfg[i];
    s = s % 256;
    d = ((s - mcfg[5]) % 256 + 256) % 256;
    return (d >= 128) ? 0 : s;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.m_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Reference model: follows accepted transfers at the edge they occur
  always @(negedge clk) begin
    if (!rst_n) begin
      smp_q.delete();
      for (int i = 0; i < 6; i++) mcfg[i] = 0;
`ifdef PFEED_STATS_EN
      m_vec = 0;
      m_zero = 0;
`endif
    end else begin
      if (cfg_we && cfg_ready) begin
        if (cfg_addr < 3'd6) mcfg[cfg_addr] = int'(cfg_wdata);
`ifdef PFEED_STATS_EN
        if (cfg_addr == 3'd7) begin
          m_vec = 0;
          m_zero = 0;
        end
`endif
      end
      if (bus.s_valid && bus.s_ready) begin
        smp_q.push_back(int'(bus.s_data));
        if (bus.s_last && smp_q.size() == 4) begin
          exp_q.push_back(ref_out(smp_q));
`ifdef PFEED_STATS_EN
          if (m_vec < 65535) m_vec++;
          if (ref_out(smp_q) == 0 && m_zero < 65535) m_zero++;
`endif
          smp_q.delete();
        end else if (bus.s_last || smp_q.size() == 4) begin
          err_exp++;
          smp_q.delete();
        end
      end
    end
  end

  // Monitor: pops expectations on result handshakes, checks hold stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (frame_err) err_seen++;
      if (stalled) begin
        check("hold_valid", int'(bus.m_valid), 1);
        check("hold_data", int'(bus.m_data), held);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(bus.m_data), -1);
        end else begin
          check("m_data", int'(bus.m_data), exp_q.pop_front());
        end
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = int'(bus.m_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cfg(input int a, input int d);
    bit ok;
    ok = 0;
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_wdata = 8'(d);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_accept", int'(ok), 1);
  endtask

  task automatic send_beat(input int d, input bit last);
    bit ok;
    ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'(d);
    bus.s_last = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    check("beat_accept", int'(ok), 1);
  endtask

  task automatic send_vec(input int a, input int b, input int c, input int d);
    send_beat(a, 0);
    send_beat(b, 0);
    send_beat(c, 0);
    send_beat(d, 1);
  endtask

  task automatic set_cfg(input int w, input int b, input int t);
    for (int i = 0; i < 4; i++) write_cfg(i, w);
    write_cfg(4, b);
    write_cfg(5, t);
  endtask

  task automatic wait_mvalid();
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        ok = 1;
        break;
      end
    end
    check("m_valid_seen", int'(ok), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b1;
    tick(2);
    check("rst_s_ready", int'(bus.s_ready), 1);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_p_bus", int'(|{p_in0, p_in1, p_in2, p_in3, p_w0, p_w1,
                              p_w2, p_w3, p_bias, p_thresh}), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic vector and latency
    set_cfg(1, 0, 0);
    send_vec(1, 2, 3, 4);
    @(negedge clk);
    check("lat_eval_m_valid", int'(bus.m_valid), 0);
    check("lat_eval_s_ready", int'(bus.s_ready), 0);
    check("lat_eval_cfg_ready", int'(cfg_ready), 0);
    @(negedge clk);
    check("lat_m_valid", int'(bus.m_valid), 1);
    check("basic_m_data", int'(bus.m_data), 10);
    tick(2);

    // Threshold clamp and pass-through
    write_cfg(5, 20);
    send_vec(1, 2, 3, 4);
    write_cfg(5, 5);
    send_vec(1, 2, 3, 4);

    // Overflow wrap
    set_cfg(16, 0, 0);
    send_vec(4, 4, 4, 4);

    // Backpressure with a bias write during HOLD
    set_cfg(1, 0, 0);
    ready_force = 0;
    tick(2);
    send_vec(1, 2, 3, 4);
    wait_mvalid();
    write_cfg(4, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_m_valid", int'(bus.m_valid), 1);
      check("bp_m_data", int'(bus.m_data), 10);
      check("bp_s_ready", int'(bus.s_ready), 0);
    end
    tick(1);
    ready_force = 1;
    send_vec(1, 2, 3, 4);
    tick(4);

    // Config write in the same cycle as the last beat
    write_cfg(4, 0);
    send_beat(2, 0);
    send_beat(2, 0);
    send_beat(2, 0);
    cfg_we = 1'b1;
    cfg_addr = 3'd4;
    cfg_wdata = 8'd7;
    send_beat(2, 1);
    cfg_we = 1'b0;
    tick(4);
    write_cfg(4, 0);

    // Framing error
    send_beat(5, 0);
    send_beat(6, 1);
    @(negedge clk);
    check("frame_pulse", int'(frame_err), 1);
    check("frame_no_valid", int'(bus.m_valid), 0);
    @(negedge clk);
    check("frame_one_cycle", int'(frame_err), 0);
    tick(1);
    send_vec(1, 1, 1, 1);
    tick(4);

    // Async reset mid-vector
    send_beat(9, 0);
    send_beat(9, 0);
    rst_n = 1'b0;
    #1;
    check("arst_s_ready", int'(bus.s_ready), 1);
    check("arst_m_valid", int'(bus.m_valid), 0);
    check("arst_p_in", int'(p_in0) + int'(p_in1), 0);
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    set_cfg(1, 0, 0);
    send_vec(3, 3, 3, 3);
    tick(4);

    // Async reset mid-HOLD loses the pending result
    ready_force = 0;
    tick(2);
    send_vec(1, 1, 1, 1);
    wait_mvalid();
    do_reset();
    ready_force = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rst_m_valid", int'(bus.m_valid), 0);
    end
    tick(1);

    // Randomized traffic
    set_cfg(1, 0, 0);
    rnd_en = 1;
    for (int v = 0; v < 60; v++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end else if (kind < 8) begin
        for (int i = 0; i < 4; i++) begin
          send_beat(int'($urandom_range(0, 255)), i == 3);
          if ($urandom_range(0, 3) == 0) tick(1);
        end
      end else begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++)
          send_beat(int'($urandom_range(0, 255)), (i == len - 1) && (len < 4));
      end
    end
    rnd_en = 0;
    ready_force = 1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick(1);
    tick(3);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frame_err_count", err_seen, err_exp);
`ifdef PFEED_STATS_EN
    check("stat_vec_cnt", int'(stat_vec_cnt), m_vec);
    check("stat_zero_cnt", int'(stat_zero_cnt), m_zero);
    write_cfg(7, 0);
    tick(1);
    check("stat_clr_vec", int'(stat_vec_cnt), 0);
    check("stat_clr_zero", int'(stat_zero_cnt), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perceptron_feeder.md
Name: perceptron_feeder

Overview:
Sequential front-end for the combinational 4-input perceptron stage. It holds the config registers (weights, bias, threshold), accepts a byte stream of input samples over valid/ready and assembles 4-sample vectors. It presents each vector stably to the perceptron for one evaluation cycle, then registers the result and returns it over valid/ready. The perceptron sits between the p_* outputs and the p_out input of this block.

Parameters:
DW, 8, width of samples, weights, bias, threshold and result; must match the perceptron stage.
CFG_AW, 3, config address width.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input sample valid
s_ready  output  1  input sample accepted when s_valid & s_ready
s_data  input  DW  input sample
s_last  input  1  marks the final sample of a vector
cfg_we  input  1  config write strobe
cfg_addr  input  CFG_AW  0-3 weight0-3, 4 bias, 5 threshold, 6-7 reserved
cfg_wdata  input  DW  config write data
cfg_ready  output  1  config write accepted when cfg_we & cfg_ready
p_in0..p_in3  output  DW each  vector to perceptron
p_w0..p_w3  output  DW each  weights to perceptron
p_bias  output  DW  bias to perceptron
p_thresh  output  DW  threshold to perceptron
p_out  input  DW  perceptron result
m_valid  output  1  result valid
m_ready  input  1  downstream accepts result
m_data  output  DW  registered result
frame_err  output  1  one-cycle pulse on a malformed vector

Behaviour:
- Reset, asynchronous and active-low: all registers clear to 0. State is COLLECT, idx=0, s_ready=1, cfg_ready=1, m_valid=0, frame_err=0, and all p_* outputs are 0.
- The p_* outputs come straight from registers and are never combinational from s_data.
- FSM COLLECT:
  - s_ready=1.
  - Each accepted beat writes s_data to p_in[idx] and increments idx.
  - Beat with idx==3 and s_last=1: go to EVAL, idx=0.
  - Beat with s_last=1 and idx<3: vector discarded, idx=0, frame_err pulses next cycle, stay in COLLECT. p_in registers keep their partial contents.
  - Beat with idx==3 and s_last=0: frame_err pulses, vector discarded, idx=0.
- FSM EVAL, exactly 1 cycle:
  - s_ready=0, cfg_ready=0, so the operands are stable.
  - At the cycle end, m_data<=p_out, m_valid<=1, go to HOLD.
- FSM HOLD:
  - s_ready=0, cfg_ready=1, m_valid=1, m_data held.
  - On m_valid & m_ready: m_valid<=0, go to COLLECT. The next sample can be accepted the following cycle.
  - m_valid never drops without m_ready.
- Latency: the last beat accepted in cycle T gives EVAL in T+1 and m_valid=1 in T+2. Peak throughput is 1 vector per 6 cycles.
- Config:
  - A write takes effect the cycle after it is accepted.
  - Writes to addresses 6 and 7 are accepted and ignored.
  - A write in the same cycle as the 4th input beat is applied before EVAL, so the new value is used.
- Arithmetic belongs to the perceptron stage. This block passes values unmodified; m_data is exactly p_out.
- Reset asserted mid-vector or mid-HOLD clears everything immediately. The pending result is lost and no m_valid is issued.

Optional Feature:
PFEED_STATS_EN
- Defined: adds outputs stat_vec_cnt[15:0] and stat_zero_cnt[15:0], both reset to 0.
  - stat_vec_cnt increments on each EVAL.
  - stat_zero_cnt increments on each EVAL with p_out==0.
  - Both saturate at 16'hFFFF.
  - Both are cleared by a cfg write to address 7, which is otherwise reserved.
- Undefined: no counter ports and no counter logic; address 7 is ignored.

Decomposition:
- Package pfeed_pkg holds:
  - state enum {COLLECT, EVAL, HOLD};
  - cfg address constants CFG_W0..CFG_W3=0..3, CFG_BIAS=4, CFG_THRESH=5, CFG_STATCLR=7;
  - DW default.
- One sub-module, pfeed_cfg_regs, holds the weight/bias/threshold register file and its write decode.
- The FSM and vector assembly stay in perceptron_feeder.

Test Plan:
- Basic vector: cfg w0..w3=1, bias=0, thresh=0; stream 1,2,3,4 with s_last on 4 → m_valid 2 cycles after the last beat, m_data=10.
- Threshold clamp: same weights, bias=0, thresh=20; stream 1,2,3,4 → m_data=0 (10-20 has MSB set). With thresh=5 → m_data=10, not 5.
- Overflow wrap: w0..w3=16, bias=0, thresh=0; stream 4,4,4,4 → perceptron 8-bit sum 256 mod 256 → m_data=0. With PFEED_STATS_EN, stat_zero_cnt=1.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid → m_valid and m_data stable, s_ready=0 throughout; a cfg write to bias during HOLD is accepted; after m_ready, the next vector uses the new bias.
- Framing: stream 5,6 with s_last on 6 → frame_err one pulse, no m_valid. Then a well-formed 1,1,1,1 → m_data=4 (weights 1, bias 0).
- Async reset: assert rst_n=0 after 2 beats → s_ready=1, m_valid=0, p_in*=0 immediately. After release, a full vector produces the correct result.
